ca_rule_engine: RTL and testbench
=================================

Name: ca_rule_engine

Overview:
- Parametrised successor to the single-rule 3-input truth-table gates: a WIDTH-cell one-dimensional elementary cellular automaton.
- The 8-bit rule is programmed at runtime, not fixed.
- The engine loads a seed and then advances a requested number of generations, one per clock.
- Sits as a programmable logic/sequence core in the DNACompiler sample set. Drives state_out to downstream logic and reports completion with a done pulse.

Parameters:
- WIDTH, 16, number of cells (>= 3).
- GEN_W, 16, width of the generation-count request and counter.
- RESET_RULE, 8'h63, rule loaded at reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_we  input  1  write cfg_rule/cfg_wrap. Honoured only in IDLE.
- cfg_rule  input  8  rule byte.
- cfg_wrap  input  1  1 = toroidal boundary; 0 = constant-0 boundary.
- load_valid  input  1  seed present.
- load_ready  output  1  high in IDLE only.
- load_data  input  WIDTH  seed value.
- start  input  1  begin run. Sampled in IDLE only.
- run_gens  input  GEN_W  generations to run. Sampled with start.
- abort  input  1  stop run at the next edge.
- busy  output  1  high in RUN.
- done  output  1  single-cycle completion pulse.
- gen_count  output  GEN_W  generations applied in the current or last run.
- state_out  output  WIDTH  current cell vector; bit i = cell i.

Behaviour:
- Reset values (async, rst_n=0):
  - state_out=0, gen_count=0, busy=0, done=0, load_ready=0.
  - rule=RESET_RULE, wrap=0, FSM=IDLE.
  - load_ready rises on the first clock after reset release.
- Rule encoding:
  - Cell i neighbourhood idx = {L,C,R}, where L=cell[i+1], C=cell[i], R=cell[i-1].
  - next = rule[7-idx], so idx 3'b000 selects rule[7].
  - Example, rule 8'h63 (0110_0011): 000->0, 001->1, 010->1, 011->0, 100->0, 101->0, 110->1, 111->1.
- Boundary:
  - wrap=1: cell[WIDTH-1] is R of cell 0 and cell 0 is L of cell WIDTH-1.
  - wrap=0: out-of-range neighbours read 0.
- IDLE:
  - cfg_we: rule/wrap updated at the edge.
  - load_valid&&load_ready: state_out<=load_data at the edge.
  - start with run_gens=N:
    - If load and start coincide, the load is applied first and start is ignored that cycle.
    - N==0: go to DONE; gen_count<=0; state unchanged.
    - N>0: gen_count<=0, latch N, go to RUN.
- RUN:
  - Each edge applies exactly one generation to all cells in parallel; gen_count increments.
  - On the edge applying generation N, go to DONE.
  - Latency: start at edge k; state_out holds gen j after edge k+j; done is high in the cycle after edge k+N.
  - cfg_we, load_valid and start are ignored in RUN.
  - abort: next edge goes to DONE with no further generation applied; gen_count holds.
  - abort has priority over the final step.
- DONE: done=1 for one cycle, then IDLE. start in DONE is ignored.
- gen_count wraps modulo 2^GEN_W. run_gens <= 2^GEN_W-1 so no overflow occurs in a run.
- Reset mid-run: immediate return to reset values; the run is lost.

Decomposition:
- Package ca_pkg:
  - FSM enum {IDLE, RUN, DONE}.
  - RULE_W=8.
  - Function rule_lookup(rule, l, c, r).
- Sub-module ca_cell: combinational one-cell next-state lookup (rule, l, c, r -> next). Instantiated WIDTH times by a generate loop in ca_rule_engine.

Test Plan:
- Reset with rst_n asserted mid-cycle -> all outputs 0 asynchronously; first run with no cfg write uses rule 8'h63.
- WIDTH=8, rule 8'h63, wrap=0, load 8'h01, start N=2 -> state 8'h03 after gen 1, 8'h05 after gen 2; done pulse the cycle after; gen_count=2; busy high for exactly 2 cycles.
- wrap=1, load 8'h80, N=1 -> 8'h81. Same with wrap=0 -> 8'h80.
- start with N=0 -> done the next cycle; state and gen_count=0 unchanged; busy never high.
- N=10 with abort asserted after 3 generations -> gen_count=3, state = gen-3 value, one done pulse.
- Writes during RUN (cfg_we rule 8'hFF, load_valid, start) -> all ignored; the run completes with the original rule; load_ready=0 throughout.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and the rule-table lookup for the elementary cellular automaton engine.
// A cell reads rule[7-idx], where idx = {left, centre, right}.
package ca_pkg;

    localparam int RULE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ca_state_e;

    function automatic logic rule_lookup(input logic [RULE_W-1:0] rule,
                                         input logic l,
                                         input logic c,
                                         input logic r);
        logic [2:0] idx;
        idx = {l, c, r};
        return rule[3'd7 - idx];
    endfunction

endpackage

// File: rtl/ca_cell.sv
// Next-state lookup for one cell. It is purely combinational, so it adds no latency.
// It has no handshake and therefore no backpressure.
module ca_cell
    import ca_pkg::*;
(
    input  logic [RULE_W-1:0] rule_i,
    input  logic              l_i,
    input  logic              c_i,
    input  logic              r_i,
    output logic              next_o
);

    assign next_o = rule_lookup(rule_i, l_i, c_i, r_i);

endmodule

// File: rtl/ca_rule_engine.sv
// A WIDTH-cell elementary cellular automaton that applies one generation per clock after start.
// Done pulses one cycle after the final generation. load_ready is high only in IDLE.
module ca_rule_engine
    import ca_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          GEN_W      = 16,
    parameter logic [7:0]  RESET_RULE = 8'h63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [RULE_W-1:0] cfg_rule,
    input  logic              cfg_wrap,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              start,
    input  logic [GEN_W-1:0]  run_gens,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  gen_count,
    output logic [WIDTH-1:0]  state_out
);

    ca_state_e         state_q, state_d;
    logic [WIDTH-1:0]  cells_q, cells_d, cells_nxt;
    logic [GEN_W-1:0]  gen_q, gen_d, gen_inc;
    logic [GEN_W-1:0]  target_q, target_d;
    logic [RULE_W-1:0] rule_q, rule_d;
    logic              wrap_q, wrap_d;
    logic              ready_q;

    // Constant-0 boundary cells are handled by masking the wrapped neighbour with wrap_q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic l, r;
        if (i == WIDTH - 1) begin : g_l_edge
            assign l = wrap_q & cells_q[0];
        end else begin : g_l_in
            assign l = cells_q[i+1];
        end
        if (i == 0) begin : g_r_edge
            assign r = wrap_q & cells_q[WIDTH-1];
        end else begin : g_r_in
            assign r = cells_q[i-1];
        end
        ca_cell u_cell (
            .rule_i (rule_q),
            .l_i    (l),
            .c_i    (cells_q[i]),
            .r_i    (r),
            .next_o (cells_nxt[i])
        );
    end

    assign gen_inc = gen_q + GEN_W'(1);

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        gen_d    = gen_q;
        target_d = target_q;
        rule_d   = rule_q;
        wrap_d   = wrap_q;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    rule_d = cfg_rule;
                    wrap_d = cfg_wrap;
                end
                // A seed load takes precedence over a coincident start.
                if (load_valid && ready_q) begin
                    cells_d = load_data;
                end else if (start) begin
                    gen_d = '0;
                    if (run_gens == '0) begin
                        state_d = DONE;
                    end else begin
                        target_d = run_gens;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    cells_d = cells_nxt;
                    gen_d   = gen_inc;
                    if (gen_inc == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cells_q  <= '0;
            gen_q    <= '0;
            target_q <= '0;
            rule_q   <= RESET_RULE;
            wrap_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            gen_q    <= gen_d;
            target_q <= target_d;
            rule_q   <= rule_d;
            wrap_q   <= wrap_d;
            ready_q  <= (state_d == IDLE);
        end
    end

    assign load_ready = ready_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign gen_count  = gen_q;
    assign state_out  = cells_q;

endmodule

// File: tb/tb_ca_rule_engine.sv
// Directed bench for ca_rule_engine with WIDTH=8, using hand-computed generations of rule 8'h63.
module tb_ca_rule_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_rule;
    logic        cfg_wrap;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        start;
    logic [15:0] run_gens;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [7:0]  state_out;

    int n_chk = 0;
    int n_bad = 0;

    ca_rule_engine #(.WIDTH(8), .GEN_W(16), .RESET_RULE(8'h63)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_rule   (cfg_rule),
        .cfg_wrap   (cfg_wrap),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .run_gens   (run_gens),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .gen_count  (gen_count),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [7:0] seed);
        load_valid = 1'b1;
        load_data  = seed;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic kick(input logic [15:0] n);
        start    = 1'b1;
        run_gens = n;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_rule = 8'h00; cfg_wrap = 1'b0;
        load_valid = 1'b0; load_data = 8'h00; start = 1'b0; run_gens = 16'd0; abort = 1'b0;

        // Reset release, then load_ready rises only after the first edge.
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rdy_pre_edge", 32'(load_ready), 32'd0);
        check("rst_state", 32'(state_out), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        tick();
        check("rdy_post_edge", 32'(load_ready), 32'd1);

        // Default rule 8'h63 with a zero boundary: 01 -> 03 -> 05.
        load_seed(8'h01);
        check("seed", 32'(state_out), 32'h01);
        kick(16'd2);
        check("run_busy0", 32'(busy), 32'd1);
        check("run_rdy0", 32'(load_ready), 32'd0);
        tick();
        check("gen1", 32'(state_out), 32'h03);
        check("gen1_cnt", 32'(gen_count), 32'd1);
        check("gen1_busy", 32'(busy), 32'd1);
        tick();
        check("gen2", 32'(state_out), 32'h05);
        check("gen2_cnt", 32'(gen_count), 32'd2);
        check("gen2_busy", 32'(busy), 32'd0);
        check("gen2_done", 32'(done), 32'd1);
        tick();
        check("done_once", 32'(done), 32'd0);
        check("idle_rdy", 32'(load_ready), 32'd1);

        // Toroidal boundary: 80 -> 81.
        cfg_we = 1'b1; cfg_rule = 8'h63; cfg_wrap = 1'b1;
        load_seed(8'h80);
        cfg_we = 1'b0;
        kick(16'd1);
        tick();
        check("wrap1", 32'(state_out), 32'h81);
        check("wrap1_done", 32'(done), 32'd1);
        tick();

        // Constant-0 boundary: 80 -> 80.
        cfg_we = 1'b1; cfg_wrap = 1'b0;
        load_seed(8'h80);
        cfg_we = 1'b0;
        kick(16'd1);
        tick();
        check("wrap0", 32'(state_out), 32'h80);
        tick();

        // A zero-generation run goes straight to DONE and clears gen_count.
        load_seed(8'h3C);
        kick(16'd0);
        check("n0_done", 32'(done), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_state", 32'(state_out), 32'h3C);
        check("n0_gen", 32'(gen_count), 32'd0);
        tick();
        check("n0_done_off", 32'(done), 32'd0);

        // Abort after gen 3 (01 -> 03 -> 05 -> 0D).
        load_seed(8'h01);
        kick(16'd10);
        tick(); tick(); tick();
        check("ab_gen3", 32'(state_out), 32'h0D);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_done", 32'(done), 32'd1);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_cnt", 32'(gen_count), 32'd3);
        check("ab_state", 32'(state_out), 32'h0D);
        tick();
        check("ab_done_once", 32'(done), 32'd0);
        check("ab_cnt_hold", 32'(gen_count), 32'd3);

        // Config, load and start attempts during RUN are all ignored.
        load_seed(8'h01);
        kick(16'd3);
        cfg_we = 1'b1; cfg_rule = 8'hFF; cfg_wrap = 1'b1;
        load_valid = 1'b1; load_data = 8'hAA; start = 1'b1; run_gens = 16'd5;
        check("ign_rdy0", 32'(load_ready), 32'd0);
        tick();
        check("ign_gen1", 32'(state_out), 32'h03);
        check("ign_rdy1", 32'(load_ready), 32'd0);
        tick();
        check("ign_gen2", 32'(state_out), 32'h05);
        tick();
        cfg_we = 1'b0; load_valid = 1'b0; start = 1'b0;
        check("ign_gen3", 32'(state_out), 32'h0D);
        check("ign_cnt", 32'(gen_count), 32'd3);
        check("ign_done", 32'(done), 32'd1);
        tick();
        load_seed(8'h01);
        kick(16'd1);
        tick();
        check("ign_rule_kept", 32'(state_out), 32'h03);
        tick();

        // Asynchronous reset mid-run, then the reset rule applies again.
        cfg_we = 1'b1; cfg_rule = 8'hFF;
        tick();
        cfg_we = 1'b0;
        load_seed(8'h01);
        kick(16'd10);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_out), 32'h00);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_gen", 32'(gen_count), 32'd0);
        check("arst_rdy", 32'(load_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        load_seed(8'h01);
        kick(16'd1);
        tick();
        check("arst_rule", 32'(state_out), 32'h03);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
